// File: rtl/spi_motor_command.sv
// SPI slave front end for the BLDC motor driver: 16-bit command frames in,
// {hall_fault, enc_count} status out, plus a host-silence watchdog.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_WAIT  | after reset; ignore any frame in flight until cs_n seen high
// S_IDLE  | bus idle, waiting for cs_n falling edge
// S_SHIFT | frame active, shifting rx on sck rise and tx on sck fall
// S_CHECK | one cycle to validate the received frame and commit/reject
module spi_motor_command #(
  parameter int DUTY_CYCLE_WIDTH = 10,
  parameter int ENC_COUNT_WIDTH  = 15,
  parameter int WATCHDOG_CYCLES  = 1000000,
  parameter int WD_WIDTH         = 20
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        spi_sck,
  input  logic                        spi_cs_n,
  input  logic                        spi_mosi,
  output logic                        spi_miso,
  output logic                        spi_miso_oe,
  input  logic [ENC_COUNT_WIDTH-1:0]  enc_count,
  input  logic                        hall_fault,
  output logic [DUTY_CYCLE_WIDTH-1:0] duty_cycle,
  output logic                        motor_en,
  output logic                        reset_counts,
  output logic                        frame_valid,
  output logic                        frame_error,
  output logic                        wd_tripped
);

  localparam logic [WD_WIDTH-1:0] WD_LAST   = WD_WIDTH'(WATCHDOG_CYCLES - 1);
  localparam logic [4:0]          CNT_FULL  = 5'd16;
  localparam logic [4:0]          CNT_SAT   = 5'd17;

  typedef enum logic [1:0] {
    S_WAIT,
    S_IDLE,
    S_SHIFT,
    S_CHECK
  } state_t;

  state_t state, state_nxt;

  logic sck_s1, sck_s2, sck_d;
  logic cs_s1, cs_s2, cs_d;
  logic mosi_s1, mosi_s2;

  logic sck_rise, sck_fall, cs_fall, cs_rise;

  logic [15:0]         tx_shift;
  logic [15:0]         rx_shift;
  logic [4:0]          bit_cnt;
  logic [WD_WIDTH-1:0] wd_cnt;
  logic [15:0]         status_word;
  logic                frame_ok;

  logic load_tx;
  logic shifting;
  logic commit;
  logic reject;
  logic end_frame;

  // cs_n sync flops reset low so S_WAIT holds until a real high is seen at the pin
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sck_s1  <= 1'b0;
      sck_s2  <= 1'b0;
      sck_d   <= 1'b0;
      cs_s1   <= 1'b0;
      cs_s2   <= 1'b0;
      cs_d    <= 1'b0;
      mosi_s1 <= 1'b0;
      mosi_s2 <= 1'b0;
    end else begin
      sck_s1  <= spi_sck;
      sck_s2  <= sck_s1;
      sck_d   <= sck_s2;
      cs_s1   <= spi_cs_n;
      cs_s2   <= cs_s1;
      cs_d    <= cs_s2;
      mosi_s1 <= spi_mosi;
      mosi_s2 <= mosi_s1;
    end
  end

  assign sck_rise = sck_s2 & ~sck_d;
  assign sck_fall = ~sck_s2 & sck_d;
  assign cs_fall  = ~cs_s2 & cs_d;
  assign cs_rise  = cs_s2 & ~cs_d;

  assign status_word = {hall_fault, 15'(enc_count)};
  assign frame_ok    = (bit_cnt == CNT_FULL) && (rx_shift[13:10] == 4'd0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_WAIT;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_WAIT:  if (cs_s2)   state_nxt = S_IDLE;
      S_IDLE:  if (cs_fall) state_nxt = S_SHIFT;
      S_SHIFT: if (cs_rise) state_nxt = S_CHECK;
      S_CHECK: state_nxt = S_IDLE;
      default: state_nxt = S_WAIT;
    endcase
  end

  always_comb begin
    load_tx   = 1'b0;
    shifting  = 1'b0;
    commit    = 1'b0;
    reject    = 1'b0;
    end_frame = 1'b0;
    case (state)
      S_IDLE:  load_tx = cs_fall;
      S_SHIFT: shifting = 1'b1;
      S_CHECK: begin
        end_frame = 1'b1;
        commit    = frame_ok;
        reject    = ~frame_ok;
      end
      default: ;
    endcase
  end

  // MISO is the MSB of the tx register, so clearing it at frame end parks MISO low
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_shift    <= 16'd0;
      rx_shift    <= 16'd0;
      bit_cnt     <= 5'd0;
      spi_miso_oe <= 1'b0;
    end else if (load_tx) begin
      tx_shift    <= status_word;
      rx_shift    <= 16'd0;
      bit_cnt     <= 5'd0;
      spi_miso_oe <= 1'b1;
    end else if (shifting) begin
      if (sck_rise) begin
        rx_shift <= {rx_shift[14:0], mosi_s2};
        if (bit_cnt != CNT_SAT) begin
          bit_cnt <= bit_cnt + 5'd1;
        end
      end
      if (sck_fall) begin
        tx_shift <= {tx_shift[14:0], 1'b0};
      end
    end else if (end_frame) begin
      tx_shift    <= 16'd0;
      spi_miso_oe <= 1'b0;
    end
  end

  assign spi_miso = tx_shift[15];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_valid  <= 1'b0;
      frame_error  <= 1'b0;
      reset_counts <= 1'b0;
    end else begin
      frame_valid  <= commit;
      frame_error  <= reject;
      reset_counts <= commit & rx_shift[14];
    end
  end

  // A commit in the same cycle as expiry takes priority over the trip
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      duty_cycle <= '0;
      motor_en   <= 1'b0;
      wd_tripped <= 1'b0;
      wd_cnt     <= '0;
    end else if (commit) begin
      duty_cycle <= DUTY_CYCLE_WIDTH'(rx_shift[9:0]);
      motor_en   <= rx_shift[15];
      wd_tripped <= 1'b0;
      wd_cnt     <= '0;
    end else if (!wd_tripped) begin
      if (wd_cnt == WD_LAST) begin
        duty_cycle <= '0;
        motor_en   <= 1'b0;
        wd_tripped <= 1'b1;
      end else begin
        wd_cnt <= wd_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_spi_motor_command.sv
// Directed bench for spi_motor_command: one instance with a long watchdog for
// frame tests, one with WATCHDOG_CYCLES=100 for the expiry test.
module tb_spi_motor_command;

  logic        clk = 1'b0;
  logic        reset;
  logic        spi_sck;
  logic        spi_cs_n;
  logic        spi_mosi;
  logic [14:0] enc_count;
  logic        hall_fault;

  logic        spi_miso, spi_miso_oe;
  logic [9:0]  duty_cycle;
  logic        motor_en, reset_counts, frame_valid, frame_error, wd_tripped;

  logic        w_miso, w_miso_oe;
  logic [9:0]  w_duty;
  logic        w_en, w_reset_counts, w_frame_valid, w_frame_error, w_tripped;

  always #5 clk = ~clk;

  spi_motor_command #(
    .DUTY_CYCLE_WIDTH(10), .ENC_COUNT_WIDTH(15),
    .WATCHDOG_CYCLES(4000), .WD_WIDTH(12)
  ) dut (
    .clk(clk), .reset(reset), .spi_sck(spi_sck), .spi_cs_n(spi_cs_n),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
    .enc_count(enc_count), .hall_fault(hall_fault), .duty_cycle(duty_cycle),
    .motor_en(motor_en), .reset_counts(reset_counts), .frame_valid(frame_valid),
    .frame_error(frame_error), .wd_tripped(wd_tripped)
  );

  spi_motor_command #(
    .DUTY_CYCLE_WIDTH(10), .ENC_COUNT_WIDTH(15),
    .WATCHDOG_CYCLES(100), .WD_WIDTH(7)
  ) dut_wd (
    .clk(clk), .reset(reset), .spi_sck(spi_sck), .spi_cs_n(spi_cs_n),
    .spi_mosi(spi_mosi), .spi_miso(w_miso), .spi_miso_oe(w_miso_oe),
    .enc_count(enc_count), .hall_fault(hall_fault), .duty_cycle(w_duty),
    .motor_en(w_en), .reset_counts(w_reset_counts), .frame_valid(w_frame_valid),
    .frame_error(w_frame_error), .wd_tripped(w_tripped)
  );

  int checks = 0;
  int errors = 0;
  int fv_n = 0, fe_n = 0, rc_n = 0, rc_stray = 0;

  always @(negedge clk) begin
    if (frame_valid) fv_n++;
    if (frame_error) fe_n++;
    if (reset_counts) rc_n++;
    if (reset_counts && !frame_valid) rc_stray++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // sck = clk/8; bits change while sck low, MISO sampled just before sck rises
  task automatic send_bit(input logic b, output logic m);
    spi_mosi = b;
    clks(4);
    m = spi_miso;
    spi_sck = 1'b1;
    clks(4);
    spi_sck = 1'b0;
  endtask

  task automatic cs_high();
    clks(4);
    spi_cs_n = 1'b1;
  endtask

  task automatic frame(input logic [15:0] d, input int n, output logic [15:0] r);
    logic m;
    r = 16'd0;
    spi_cs_n = 1'b0;
    for (int i = 0; i < n; i++) begin
      send_bit(d[15-i], m);
      r[15-i] = m;
    end
    cs_high();
  endtask

  logic [15:0] rx;
  logic [15:0] d;
  logic        m;
  int          fv0, fe0;

  logic [15:0] bb_data [3] = '{16'h8123, 16'h83FF, 16'h8001};
  logic [14:0] bb_enc  [3] = '{15'h0ABC, 15'h7FFF, 15'h0000};
  logic        bb_hall [3] = '{1'b0, 1'b1, 1'b1};
  logic [15:0] bb_stat [3] = '{16'h0ABC, 16'hFFFF, 16'h8000};

  initial begin
    #2_000_000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; spi_cs_n = 1'b1; spi_sck = 1'b0; spi_mosi = 1'b0;
    enc_count = 15'h1234; hall_fault = 1'b1;
    clks(5);
    chk("rst_duty", duty_cycle, 0);
    chk("rst_en", motor_en, 0);
    chk("rst_wd", wd_tripped, 0);
    chk("rst_miso", spi_miso, 0);
    chk("rst_oe", spi_miso_oe, 0);
    chk("rst_pulses", {frame_valid, frame_error, reset_counts}, 0);
    reset = 1'b0;
    clks(5);

    // basic commit, MISO status and commit latency
    frame(16'h8200, 16, rx);
    chk("miso_8200", rx, 16'h9234);
    clks(3);
    chk("fv_lat3", frame_valid, 0);
    clks(1);
    chk("fv_lat4", frame_valid, 1);
    chk("duty_lat4", duty_cycle, 10'h200);
    clks(1);
    chk("fv_lat5", frame_valid, 0);
    clks(11);
    chk("duty_8200", duty_cycle, 10'h200);
    chk("en_8200", motor_en, 1);
    chk("fv_n_8200", fv_n, 1);
    chk("rc_n_8200", rc_n, 0);
    chk("oe_after", spi_miso_oe, 0);

    // reset_counts request
    frame(16'hC005, 16, rx);
    clks(16);
    chk("duty_c005", duty_cycle, 10'h005);
    chk("en_c005", motor_en, 1);
    chk("rc_n_c005", rc_n, 1);
    chk("rc_stray", rc_stray, 0);
    chk("fv_n_c005", fv_n, 2);

    // short frame and reserved bits both rejected
    frame(16'h8200, 16, rx);
    clks(16);
    frame(16'h8300, 12, rx);
    clks(16);
    frame(16'h8C00, 16, rx);
    clks(16);
    chk("fe_n", fe_n, 2);
    chk("fv_n_err", fv_n, 3);
    chk("duty_err", duty_cycle, 10'h200);
    chk("en_err", motor_en, 1);

    // watchdog expiry at exactly 100 clk after commit
    frame(16'h8100, 16, rx);
    clks(103);
    chk("wd_pre", w_tripped, 0);
    chk("wd_pre_duty", w_duty, 10'h100);
    chk("wd_pre_en", w_en, 1);
    clks(1);
    chk("wd_trip", w_tripped, 1);
    chk("wd_trip_duty", w_duty, 0);
    chk("wd_trip_en", w_en, 0);
    chk("main_no_trip", wd_tripped, 0);
    chk("main_duty_8100", duty_cycle, 10'h100);
    clks(20);
    chk("wd_hold", w_tripped, 1);
    frame(16'h8080, 16, rx);
    clks(6);
    chk("wd_clr_duty", w_duty, 10'h080);
    chk("wd_clr", w_tripped, 0);
    chk("wd_clr_en", w_en, 1);
    clks(10);

    // reset in the middle of a frame
    fv0 = fv_n; fe0 = fe_n;
    d = 16'h8020;
    spi_cs_n = 1'b0;
    for (int i = 0; i < 8; i++) send_bit(d[15-i], m);
    clks(1);
    reset = 1'b1;
    clks(2);
    chk("mid_rst_duty", duty_cycle, 0);
    chk("mid_rst_en", motor_en, 0);
    chk("mid_rst_oe", spi_miso_oe, 0);
    reset = 1'b0;
    for (int i = 8; i < 16; i++) send_bit(d[15-i], m);
    cs_high();
    clks(16);
    chk("mid_rst_fv", fv_n - fv0, 0);
    chk("mid_rst_fe", fe_n - fe0, 0);
    chk("mid_rst_duty2", duty_cycle, 0);
    chk("mid_rst_en2", motor_en, 0);
    frame(16'h8010, 16, rx);
    clks(16);
    chk("post_rst_duty", duty_cycle, 10'h010);
    chk("post_rst_en", motor_en, 1);

    // back-to-back frames, status changed after the snapshot point
    fv0 = fv_n;
    for (int k = 0; k < 3; k++) begin
      enc_count = bb_enc[k];
      hall_fault = bb_hall[k];
      clks(8);
      d = bb_data[k];
      rx = 16'd0;
      spi_cs_n = 1'b0;
      for (int i = 0; i < 16; i++) begin
        send_bit(d[15-i], m);
        rx[15-i] = m;
        if (i == 0) begin
          enc_count = ~bb_enc[k];
          hall_fault = ~bb_hall[k];
        end
      end
      cs_high();
      clks(8);
      chk("b2b_miso", rx, bb_stat[k]);
      chk("b2b_duty", duty_cycle, {22'd0, bb_data[k][9:0]});
    end
    clks(8);
    chk("b2b_fv_n", fv_n - fv0, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
